comparator_serial_ctrl: RTL and testbench

//  Sequences a wide unsigned less-than compare (A < B) over a narrow SLICE_W-bit slice comparator, MSB slice first.

---
 rtl/comparator_serial_ctrl.sv | 146 ++++++++++++++
 tb/tb_comparator_serial_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial_ctrl.sv
// comparator_serial_ctrl
// Wide unsigned compare (A < B, A == B) done serially over SLICE_W-bit slices,
// most significant slice first, with valid/ready handshakes on both sides.
// Optional build macro: CMP_EARLY_EXIT_EN -- finish as soon as a slice decides.
module comparator_serial_ctrl #(
    parameter int DATA_W  = 128,
    parameter int SLICE_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      A,
    input  logic [DATA_W-1:0]                      B,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   LT,
    output logic                                   EQ,
    output logic [$clog2(DATA_W/SLICE_W+1)-1:0]    slices_used,
    output logic                                   busy
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = $clog2(NUM_SLICES + 1);
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if ((SLICE_W < 1) || (DATA_W < SLICE_W) || ((DATA_W % SLICE_W) != 0)) begin : g_width_check
        $error("comparator_serial_ctrl: DATA_W must be a non-zero multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_W-1:0]    a_sh;
    logic [DATA_W-1:0]    b_sh;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     count;
    logic                 decided;
    logic                 result;
    logic [SLICE_W-1:0]   a_slice;
    logic [SLICE_W-1:0]   b_slice;
    logic                 slice_ne;
    logic                 slice_lt;
    logic                 accept;
    logic                 release_out;

    // Operands are shifted left each COMPARE cycle so the slice under test is
    // always the top SLICE_W bits; this replaces a variable part-select on idx.
    assign a_slice  = a_sh[DATA_W-1 -: SLICE_W];
    assign b_slice  = b_sh[DATA_W-1 -: SLICE_W];
    assign slice_ne = (a_slice != b_slice);
    assign slice_lt = (a_slice < b_slice);

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    // Results are only exposed in DONE so that reset and idle read as zero.
    assign LT          = out_valid && decided && result;
    assign EQ          = out_valid && !decided;
    assign slices_used = out_valid ? count : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (idx == '0) begin
                    state_nxt = DONE;
                end
`ifdef CMP_EARLY_EXIT_EN
                if (!decided && slice_ne) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice walk and decision tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            idx     <= '0;
            count   <= '0;
            decided <= 1'b0;
            result  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        idx     <= IDX_W'(NUM_SLICES - 1);
                        count   <= '0;
                        decided <= 1'b0;
                        result  <= 1'b0;
                    end
                end
                COMPARE: begin
                    a_sh  <= a_sh << SLICE_W;
                    b_sh  <= b_sh << SLICE_W;
                    count <= count + 1'b1;
                    if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                    if (!decided && slice_ne) begin
                        decided <= 1'b1;
                        result  <= slice_lt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial_ctrl.sv
// Testbench for comparator_serial_ctrl (DATA_W=128, SLICE_W=32).
// Reference model computes A<B, A==B, slices examined and latency directly
// from the operands; a negedge monitor compares every presented result.
module tb_comparator_serial_ctrl;

    localparam int DATA_W  = 128;
    localparam int SLICE_W = 32;
    localparam int NS      = DATA_W / SLICE_W;
    localparam int CNT_W   = $clog2(NS + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  A;
    logic [DATA_W-1:0]  B;
    logic               out_valid;
    logic               out_ready;
    logic               LT;
    logic               EQ;
    logic [CNT_W-1:0]   slices_used;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en     = 1'b0;
    logic rand_ready = 1'b0;
    logic seen       = 1'b0;

    typedef struct {
        logic lt;
        logic eq;
        int   used;
        int   acc;
    } exp_t;

    exp_t q[$];

    comparator_serial_ctrl #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .LT          (LT),
        .EQ          (EQ),
        .slices_used (slices_used),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int acc);
        exp_t e;
        e.lt   = (a < b);
        e.eq   = (a == b);
        e.used = NS;
`ifdef CMP_EARLY_EXIT_EN
        for (int s = NS - 1; s >= 0; s--) begin
            if (a[s*SLICE_W +: SLICE_W] != b[s*SLICE_W +: SLICE_W]) begin
                e.used = NS - s;
                break;
            end
        end
`endif
        e.acc = acc;
        return e;
    endfunction

    // Monitor: every cycle, compare presented results with the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else if (mon_en) begin
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, cyc));
            end
            check("busy_vs_in_ready", busy, !in_ready);
            check("lt_eq_exclusive", LT & EQ, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    if (!seen) begin
                        check("latency", cyc, q[0].acc + q[0].used + 1);
                        seen = 1'b1;
                    end
                    check("LT", LT, q[0].lt);
                    check("EQ", EQ, q[0].eq);
                    check("slices_used", slices_used, q[0].used);
                    check("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Present operands and return just after the acceptance edge.
    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, output int t0);
        int n;
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic ok);
        int n;
        n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            checks++;
            errors++;
            $display("FAIL result_timeout: got out_valid 0 expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic directed(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input int exp_lt, input int exp_eq, input int exp_used, input int exp_lat);
        int   t0;
        logic ok;
        send(a, b, t0);
        wait_out(ok);
        if (ok) begin
            check({name, "_latency"}, cyc - t0, exp_lat);
            check({name, "_LT"}, LT, exp_lt);
            check({name, "_EQ"}, EQ, exp_eq);
            check({name, "_used"}, slices_used, exp_used);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               t0;
        logic             ok;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] msb;
        logic [DATA_W-1:0] ones;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_LT", LT, 0);
        check("reset_EQ", EQ, 0);
        check("reset_used", slices_used, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic vectors with hand-computed expectations
        directed("t1_lt", 128'd5, 128'd6, 1, 0, 4, 5);
        msb  = '0;
        msb[DATA_W-1] = 1'b1;
`ifdef CMP_EARLY_EXIT_EN
        directed("t2_msb", msb, '0, 0, 0, 1, 2);
`else
        directed("t2_msb", msb, '0, 0, 0, 4, 5);
`endif
        ones = '1;
        directed("t3_eq", ones, ones, 0, 1, 4, 5);

        // Hold the result with out_ready low while new operands are offered
        out_ready = 1'b0;
        send(128'd7, 128'd3, t0);
        wait_out(ok);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            A = {$urandom, $urandom, $urandom, $urandom};
            B = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_LT", LT, 0);
            check("hold_EQ", EQ, 0);
            check("hold_used", slices_used, 4);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Reset during the second COMPARE cycle abandons the operation
        @(posedge clk);
        #1;
        a = {$urandom, $urandom, $urandom, $urandom};
        send(a, a, t0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;

        // Random back-to-back traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int r;
            int k;
            a = {$urandom, $urandom, $urandom, $urandom};
            b = a;
            r = $urandom_range(0, 3);
            if (r != 0) begin
                k = $urandom_range(0, NS - 1);
                for (int s = 0; s < NS; s++) begin
                    if (s < k) begin
                        b[s*SLICE_W +: SLICE_W] = $urandom;
                    end else if (s == k) begin
                        b[s*SLICE_W +: SLICE_W] = a[s*SLICE_W +: SLICE_W] ^ (32'($urandom) | 32'h1);
                    end
                end
            end
            send(a, b, t0);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check("drain_pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
